cordic_sincos_pipe: RTL

CORDIC_SINCOS_PIPE -- requirements
Module: cordic_sincos_pipe

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_stage.sv | 38 +++
 rtl/cordic_sincos_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: CORDIC gain, pi constants and atan(2^-i) table generation
package cordic_pkg;
   localparam real PI_R = 3.141592653589793;
   localparam real K_R = 0.6072529350088813;
   function automatic longint fix(input real v, input int frac);
      return longint'(v * (2.0 ** frac));
   endfunction
   // Taylor series is exact enough here since 2^-i <= 0.5 for every i > 0
   function automatic real atan_pow2(input int i);
      real x, t, s;
      if (i == 0) return PI_R / 4.0;
      x = 2.0 ** (-i);
      t = x;
      s = 0.0;
      for (int k = 0; k < 40; k++) begin
         s = s + ((k % 2 == 1) ? -t : t) / real'(2 * k + 1);
         t = t * x * x;
      end
      return s;
   endfunction
   function automatic longint atan_q(input int i, input int frac);
      return fix(atan_pow2(i), frac);
   endfunction
   function automatic longint pi_q(input int width);
      return fix(PI_R, width - 3);
   endfunction
   function automatic longint half_pi_q(input int width);
      return fix(PI_R / 2.0, width - 3);
   endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation
module cordic_stage import cordic_pkg::*; #(
   parameter int STAGE = 0,
   parameter int W = 24,
   parameter int ZF = 21
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_en,
   input  logic v,
   input  logic [1:0] f,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] z,
   output logic nv,
   output logic [1:0] nf,
   output logic [W-1:0] nx,
   output logic [W-1:0] ny,
   output logic [W-1:0] nz
);
   localparam logic signed [W-1:0] A = W'(atan_q(STAGE, ZF));
   logic signed [W-1:0] sx, sy, sz;
   logic d;
   assign sx = x;
   assign sy = y;
   assign sz = z;
   assign d = !sz[W-1];
   always_ff @(posedge clk)
      if (!reset) nv <= 1'b0;
      else if (clk_en) nv <= v;
   always_ff @(posedge clk)
      if (clk_en) begin
         nf <= f;
         nx <= d ? sx - (sy >>> STAGE) : sx + (sy >>> STAGE);
         ny <= d ? sy + (sx >>> STAGE) : sy - (sx >>> STAGE);
         nz <= d ? sz - A : sz + A;
      end
endmodule

// File: rtl/cordic_sincos_pipe.sv
// cordic_sincos_pipe: pipelined CORDIC sine/cosine with range fold, rounding and saturation
module cordic_sincos_pipe import cordic_pkg::*; #(
   parameter int WIDTH = 22,
   parameter int ITERS = 20,
   parameter int GUARD = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_en,
   input  logic in_valid,
   input  logic [WIDTH-1:0] angle,
   output logic out_valid,
   output logic [WIDTH-1:0] cos_out,
   output logic [WIDTH-1:0] sin_out,
   output logic out_err
);
   localparam int IW = WIDTH + GUARD;
   localparam int ZF = WIDTH - 3 + GUARD;
   localparam int XF = WIDTH - 2 + GUARD;
   localparam logic signed [WIDTH-1:0] PI_W = WIDTH'(pi_q(WIDTH));
   localparam logic signed [WIDTH-1:0] PI2_W = WIDTH'(half_pi_q(WIDTH));
   localparam logic signed [IW-1:0] PI_Z = IW'(fix(PI_R, ZF));
   localparam logic signed [IW-1:0] K_X = IW'(fix(K_R, XF));
   localparam logic signed [IW:0] HALF = (IW+1)'(2 ** GUARD / 2);
   localparam logic signed [IW:0] HALFM = (IW+1)'(2 ** GUARD / 2 - (GUARD > 0 ? 1 : 0));
   localparam logic signed [IW:0] LIM = (IW+1)'(1) <<< (WIDTH - 2);
   logic signed [WIDTH-1:0] a, c;
   logic signed [IW-1:0] az;
   logic hi, lo, err, neg, v0;
   logic [1:0] f0;
   logic [IW-1:0] z0;
   logic v [0:ITERS];
   logic [1:0] f [0:ITERS];
   logic [IW-1:0] x [0:ITERS];
   logic [IW-1:0] y [0:ITERS];
   logic [IW-1:0] z [0:ITERS];
   assign a = angle;
   assign hi = a > PI_W;
   assign lo = a < -PI_W;
   assign err = hi | lo;
   assign c = hi ? PI_W : (lo ? -PI_W : a);
   assign az = IW'(c) <<< GUARD;
   assign neg = (c > PI2_W) || (c < -PI2_W);
   always_ff @(posedge clk)
      if (!reset) v0 <= 1'b0;
      else if (clk_en) v0 <= in_valid;
   // fold into [-pi/2, pi/2]; the half-turn is undone by negating both results
   always_ff @(posedge clk)
      if (clk_en) begin
         z0 <= c > PI2_W ? az - PI_Z : (c < -PI2_W ? az + PI_Z : az);
         f0 <= {err, neg};
      end
   assign v[0] = v0;
   assign f[0] = f0;
   assign x[0] = K_X;
   assign y[0] = '0;
   assign z[0] = z0;
   for (genvar g = 0; g < ITERS; g++) begin : g_stage
      cordic_stage #(.STAGE(g), .W(IW), .ZF(ZF)) u_stage (
         .clk(clk), .reset(reset), .clk_en(clk_en),
         .v(v[g]), .f(f[g]), .x(x[g]), .y(y[g]), .z(z[g]),
         .nv(v[g+1]), .nf(f[g+1]), .nx(x[g+1]), .ny(y[g+1]), .nz(z[g+1]));
   end
   function automatic logic signed [WIDTH-1:0] fin(input logic signed [IW-1:0] p, input logic n);
      logic signed [IW:0] s, r;
      s = n ? -((IW+1)'(p)) : (IW+1)'(p);
      r = (s + (s < 0 ? HALFM : HALF)) >>> GUARD;
      return r > LIM ? WIDTH'(LIM) : (r < -LIM ? WIDTH'(-LIM) : r[WIDTH-1:0]);
   endfunction
   always_ff @(posedge clk)
      if (!reset) begin
         out_valid <= 1'b0;
         cos_out <= '0;
         sin_out <= '0;
         out_err <= 1'b0;
      end else if (clk_en) begin
         out_valid <= v[ITERS];
         cos_out <= fin(x[ITERS], f[ITERS][0]);
         sin_out <= fin(y[ITERS], f[ITERS][0]);
         out_err <= f[ITERS][1];
      end
endmodule
